axil_write_master: RTL

- Converts simple valid/ready write requests (address, data, strobe) into single AXI4-Lite write transactions on discrete AW/W/B channels.
- Sits between the pulse-counter result logic and the AXI slave peripherals (seven-segment controller, component ID in address bits [15:8]).
- Holds one request in a pending register, so the producer can post the next result while the current transaction is still in flight.

---
 rtl/axil_write_master.sv | 95 +++++++++
 1 files changed

// File: rtl/axil_write_master.sv
// axil_write_master: posts valid/ready write requests as single AXI4-Lite writes
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   req_valid/req_ready           request handshake (one-entry pending register)
//   req_addr/req_data/req_strb    write request payload
//   done/resp/err                 completion pulse, last BRESP, sticky error
//   aw*/w*/b*                     AXI4-Lite write address, data and response channels
module axil_write_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_data,
    input  logic [DATA_W/8-1:0] req_strb,
    output logic                done,
    output logic [1:0]          resp,
    output logic                err,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);
    typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP} state_t;
    state_t                state;
    logic                  pend_valid;
    logic [ADDR_W-1:0]     pend_addr;
    logic [DATA_W-1:0]     pend_data;
    logic [DATA_W/8-1:0]   pend_strb;
    logic                  aw_left, w_left;
    // gated by rst so nothing is accepted while reset is held
    assign req_ready = rst && !pend_valid;
    assign awprot    = 3'b000;
    // a channel still owes a handshake if its valid is up and ready is not
    assign aw_left   = awvalid && !awready;
    assign w_left    = wvalid && !wready;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            pend_valid <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            done       <= 1'b0;
            resp       <= 2'b00;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (pend_valid) begin
                    awaddr     <= pend_addr;
                    wdata      <= pend_data;
                    wstrb      <= pend_strb;
                    awvalid    <= 1'b1;
                    wvalid     <= 1'b1;
                    pend_valid <= 1'b0;
                    state      <= ADDR_DATA;
                end
                ADDR_DATA: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready) wvalid <= 1'b0;
                    if (!aw_left && !w_left) begin
                        bready <= 1'b1;
                        state  <= RESP;
                    end
                end
                RESP: if (bvalid) begin
                    bready <= 1'b0;
                    done   <= 1'b1;
                    resp   <= bresp;
                    err    <= err || (bresp != 2'b00);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // placed after the launch so an accept on the same edge wins
            if (req_valid && req_ready) begin
                pend_valid <= 1'b1;
                pend_addr  <= req_addr;
                pend_data  <= req_data;
                pend_strb  <= req_strb;
            end
        end
    end
endmodule
